// File: rtl/parity_pkg.sv
// Shared types and helpers for the framed parity
// generator/checker.
package parity_pkg;

  typedef enum logic {
    ACC = 1'b0,
    CHK = 1'b1
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parity_frame_unit.sv
// Framed XOR parity generator/checker with
// trailing parity beat and error counter.
module parity_frame_unit
  import parity_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int FRAME_BEATS = 8,
  parameter bit ODD_PARITY  = PAR_EVEN,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_last,
  input  logic                          chk_en,
  output logic                          z,
  output logic                          par_valid,
  output logic                          par_bit,
  output logic                          err,
  output logic [ERR_CNT_W-1:0]          err_cnt,
  output logic [cnt_w(FRAME_BEATS)-1:0] beat_cnt
);

  localparam int BW = cnt_w(FRAME_BEATS);
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BEATS - 1);

  state_e        state_q, state_d;
  logic          acc_q, acc_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          mode_q, mode_d;
  logic          pv_q, pv_d;
  logic          pb_q, pb_d;
  logic          err_q, err_d;

  logic acc_nx;
  logic first;
  logic mode_eff;
  logic end_beat;
  logic expected;

  assign acc_nx   = acc_q ^ (^in_data);
  assign first    = (bcnt_q == '0);
  assign mode_eff = first ? chk_en : mode_q;
  assign end_beat = in_last || (bcnt_q == LAST_IDX);
  assign expected = acc_q ^ ODD_PARITY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= 1'b0;
      bcnt_q <= '0;
      mode_q <= 1'b0;
      pv_q   <= 1'b0;
      pb_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      bcnt_q <= bcnt_d;
      mode_q <= mode_d;
      pv_q   <= pv_d;
      pb_q   <= pb_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bcnt_d  = bcnt_q;
    mode_d  = mode_q;
    pv_d    = 1'b0;
    pb_d    = pb_q;
    err_d   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ACC: begin
          if (first) mode_d = chk_en;
          if (end_beat) begin
            bcnt_d = '0;
            if (mode_eff) begin
              // keep the frame parity for the CHK beat
              acc_d   = acc_nx;
              state_d = CHK;
            end else begin
              pv_d  = 1'b1;
              pb_d  = acc_nx ^ ODD_PARITY;
              acc_d = 1'b0;
            end
          end else begin
            acc_d  = acc_nx;
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        CHK: begin
          pv_d    = 1'b1;
          pb_d    = expected;
          err_d   = (in_data[0] != expected);
          acc_d   = 1'b0;
          state_d = ACC;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_d),
    .clear(1'b0),
    .cnt  (err_cnt)
  );

  assign z         = acc_q ^ ODD_PARITY;
  assign par_valid = pv_q;
  assign par_bit   = pb_q;
  assign err       = err_q;
  assign beat_cnt  = bcnt_q;

endmodule
